// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring shift-subtract step per enabled cycle.
// Latency XLEN+1 enabled cycles; divide-by-zero and signed overflow complete on the accepting edge.
// Backpressure: ready is low while busy; rdy_in low freezes all state, stretching a pending rdy pulse.
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif

module mul_div_unit #(
    parameter int XLEN  = 32,
    parameter int ROB_W = `ROB_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [ROB_W-1:0] rob_id,
    input  logic [XLEN-1:0]  data_j,
    input  logic [XLEN-1:0]  data_k,
    output logic             ready,
    output logic             rdy,
    output logic [ROB_W-1:0] rob_id_out,
    output logic [XLEN-1:0]  result
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [ROB_W-1:0]  tag_q, tag_d, rob_id_out_q, rob_id_out_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d, result_q, result_d;
    logic              neg_q, neg_d, negr_q, negr_d, rdy_q, rdy_d;

    logic              accept, sgn_j, sgn_k, sj, sk, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_j, mag_k, special_res, quo, rem, final_res;
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] prod;

    assign ready      = (state_q != BUSY);
    assign accept     = rdy_in && en && ready && !flush;
    assign rdy        = rdy_q;
    assign rob_id_out = rob_id_out_q;
    assign result     = result_q;

    // Operand conditioning for the op being presented this cycle.
    always_comb begin
        sgn_j    = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        sgn_k    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        sj       = sgn_j && data_j[XLEN-1];
        sk       = sgn_k && data_k[XLEN-1];
        mag_j    = sj ? -data_j : data_j;
        mag_k    = sk ? -data_k : data_k;
        div_zero = op[2] && (data_k == '0);
        div_ovf  = op[2] && !op[0] && (data_j == MIN_NEG) && (data_k == '1);
        // op[1] selects remainder among the divide ops.
        if (op[1]) special_res = div_zero ? data_j : '0;
        else       special_res = div_zero ? '1 : data_j;
    end

    // Iteration datapath and final sign correction.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_sh   = acc_q[2*XLEN-1:XLEN-1];
        div_diff = div_sh - {1'b0, opb_q};
        prod     = neg_q ? -acc_q : acc_q;
        quo      = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem      = negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 final_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quo;
            default:                final_res = rem;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        tag_d        = tag_q;
        acc_d        = acc_q;
        opb_d        = opb_q;
        neg_d        = neg_q;
        negr_d       = negr_q;
        rdy_d        = rdy_q;
        rob_id_out_d = rob_id_out_q;
        result_d     = result_q;
        if (rdy_in) begin
            if (flush) begin
                state_d = IDLE;
                rdy_d   = 1'b0;
            end else if (state_q == BUSY) begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                    if (!op_q[2])              acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    else if (!div_diff[XLEN])  acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    else                       acc_d = {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end else begin
                    state_d      = DONE;
                    rdy_d        = 1'b1;
                    result_d     = final_res;
                    rob_id_out_d = tag_q;
                end
            end else begin
                state_d = IDLE;
                rdy_d   = 1'b0;
                if (accept) begin
                    op_d   = op;
                    tag_d  = rob_id;
                    neg_d  = sj ^ sk;
                    negr_d = sj;
                    opb_d  = mag_k;
                    acc_d  = {{XLEN{1'b0}}, mag_j};
                    if (div_zero || div_ovf) begin
                        state_d      = DONE;
                        cnt_d        = '0;
                        rdy_d        = 1'b1;
                        result_d     = special_res;
                        rob_id_out_d = rob_id;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CW'(XLEN);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            tag_q        <= '0;
            acc_q        <= '0;
            opb_q        <= '0;
            neg_q        <= 1'b0;
            negr_q       <= 1'b0;
            rdy_q        <= 1'b0;
            rob_id_out_q <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            tag_q        <= tag_d;
            acc_q        <= acc_d;
            opb_q        <= opb_d;
            neg_q        <= neg_d;
            negr_q       <= negr_d;
            rdy_q        <= rdy_d;
            rob_id_out_q <= rob_id_out_d;
            result_q     <= result_d;
        end
    end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, which sets the operand and result width in bits (even, at least 8).
REQ-002 The block SHALL have parameter ROB_W, default `ROB_WIDTH, which sets the reorder-buffer tag width.
REQ-003 Port clk_in SHALL be an input of width 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_in SHALL be an input of width 1: reset, asynchronous and active-low.
REQ-005 Port rdy_in SHALL be an input of width 1: global enable; when low, all state holds.
REQ-006 Port flush SHALL be an input of width 1: misprediction flush, sampled only when rdy_in is high.
REQ-007 Port en SHALL be an input of width 1: issue request.
REQ-008 Port op SHALL be an input of width 3: RV32M funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-009 Port rob_id SHALL be an input of width ROB_W: tag of the issued instruction.
REQ-010 Port data_j SHALL be an input of width XLEN: rs1 operand.
REQ-011 Port data_k SHALL be an input of width XLEN: rs2 operand.
REQ-012 Port ready SHALL be an output of width 1: combinational; high when the unit can accept an issue this cycle.
REQ-013 Port rdy SHALL be an output of width 1: result-valid pulse.
REQ-014 Port rob_id_out SHALL be an output of width ROB_W: tag of the completing result.
REQ-015 Port result SHALL be an output of width XLEN: completed value.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, BUSY and DONE; ready SHALL be high in IDLE and DONE and low in BUSY.
REQ-017 An issue SHALL be accepted on an edge where rdy_in, en and ready are all high and flush is low; en while ready is low SHALL be ignored.
REQ-018 On acceptance the unit SHALL latch op, rob_id, the operand magnitudes and the result sign.
REQ-019 Signedness SHALL be: MULH/DIV/REM both operands signed; MULHSU rs1 signed, rs2 unsigned; MULHU/DIVU/REMU and MUL unsigned-equivalent.
REQ-020 On a normal acceptance the FSM SHALL go to BUSY with iteration counter = XLEN.
REQ-021 In BUSY, multiply SHALL perform one shift-add step per enabled cycle on a 2*XLEN-bit accumulator.
REQ-022 In BUSY, divide SHALL perform one restoring shift-subtract step per enabled cycle.
REQ-023 In BUSY the counter SHALL decrement; at counter reaching 0 the FSM SHALL go to DONE.
REQ-024 Normal-op latency SHALL be XLEN+1 enabled cycles from the accepting edge to the edge at which rdy becomes 1.
REQ-025 In DONE, rdy SHALL be 1 for exactly one enabled cycle, with rob_id_out = latched tag and result = final sign-corrected value.
REQ-026 The result selection SHALL be: MUL low XLEN bits of the product; MULH/MULHSU/MULHU high XLEN bits of the sign-corrected product.
REQ-027 Divide results SHALL be: quotient sign = sign(j) XOR sign(k); remainder sign = sign(j).
REQ-028 A divisor of 0 SHALL bypass BUSY and go directly to DONE (latency 1) with quotient all-ones and remainder equal to data_j.
REQ-029 Signed DIV/REM with data_j = most-negative and data_k = -1 SHALL take latency 1, with quotient = data_j and remainder = 0.
REQ-030 Leaving DONE SHALL return the FSM to IDLE, unless a new issue is accepted on the same edge, in which case the new op SHALL start (back-to-back issue).
REQ-031 The issue acceptance of REQ-030 SHALL hold rdy, result and rob_id_out for exactly one cycle, then clear rdy.
REQ-032 flush with rdy_in high SHALL force IDLE, clear rdy, discard any in-flight op and reject a simultaneous en; no rdy pulse SHALL follow for the discarded op.
REQ-033 rdy_in low SHALL freeze the FSM, counter, datapath and outputs, including a pending rdy pulse, which is extended until rdy_in returns.

Reset
REQ-034 Asserting rst_in low SHALL immediately set the state to IDLE, rdy to 0, rob_id_out to 0, result to 0, counter to 0 and all datapath registers to 0, independent of clk_in and rdy_in.
REQ-035 Reset asserted mid-operation SHALL abandon the operation with no rdy pulse after release; the first accepting edge after release SHALL start cleanly.

Verification (XLEN=32)
REQ-036 The bench SHALL issue MUL 7 x -3 with tag 5 -> 33 cycles later a single-cycle rdy with rob_id_out=5 and result=0xFFFFFFEB.
REQ-037 The bench SHALL issue MULHU 0xFFFFFFFF x 0xFFFFFFFF and MULH 0x80000000 x 0x80000000 -> results 0xFFFFFFFE and 0x40000000 respectively.
REQ-038 The bench SHALL issue DIV -7/2, REM -7/2 and DIVU 100/7 -> results 0xFFFFFFFD, 0xFFFFFFFF and 14, each with latency 33.
REQ-039 The bench SHALL issue DIV 5/0, REMU 5/0 and DIV 0x80000000/-1 -> results 0xFFFFFFFF, 5 and 0x80000000, each with latency 1.
REQ-040 The bench SHALL assert flush 10 cycles into a DIV, then issue MUL 3x4 on the next edge -> no rdy for the DIV, then rdy with result 12 after 33 cycles.
REQ-041 The bench SHALL drop rdy_in for 5 cycles mid-MUL and also drop rst_in low mid-DIV -> MUL latency becomes 38 with the correct result; the DIV yields no rdy and all outputs are 0 immediately on reset.
